// File: rtl/wb_data_ram_if.sv
// wb_data_ram_if
// Wishbone classic single-beat bus between the load/store unit (master)
// and the data RAM (slave).
// Signals:
//   ADR    master->slave  byte address
//   DAT_W  master->slave  write data
//   SEL    master->slave  byte-lane write enables
//   WE     master->slave  1 = write, 0 = read
//   STB    master->slave  strobe, transfer request
//   CYC    master->slave  bus cycle in progress
//   DAT_R  slave->master  read data, right-aligned to the addressed byte
//   ACK    slave->master  one-cycle completion pulse
interface wb_data_ram_if #(
  parameter int XLEN = 32
);
  logic [XLEN-1:0] ADR;
  logic [XLEN-1:0] DAT_W;
  logic [3:0]      SEL;
  logic            WE;
  logic            STB;
  logic            CYC;
  logic [XLEN-1:0] DAT_R;
  logic            ACK;

  modport master (
    output ADR, DAT_W, SEL, WE, STB, CYC,
    input  DAT_R, ACK
  );

  modport slave (
    input  ADR, DAT_W, SEL, WE, STB, CYC,
    output DAT_R, ACK
  );
endinterface

// File: rtl/wb_data_ram.sv
// wb_data_ram
// Wishbone classic slave data memory behind the load/store unit. Serves
// single-beat reads and byte-lane writes after a fixed number of wait states.
// Read data is shifted right so the addressed byte lands in bits [7:0].
// Ports:
//   clk       sole clock, rising edge
//   rst       asynchronous active-high reset (array contents untouched)
//   data_bus  wishbone slave port (ADR, DAT_W, SEL, WE, STB, CYC in;
//             DAT_R, ACK out)
module wb_data_ram #(
  parameter int XLEN        = 32,
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_STATES = 1
) (
  input  logic          clk,
  input  logic          rst,
  wb_data_ram_if.slave  data_bus
);

  localparam int AW = $clog2(DEPTH_WORDS);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RESP
  } state_t;

  state_t          r_state;
  state_t          w_nextState;
  logic [3:0]      r_count;
  logic [AW-1:0]   r_index;
  logic [1:0]      r_lane;
  logic            r_we;
  logic [3:0]      r_sel;
  logic [XLEN-1:0] r_datW;
  logic [XLEN-1:0] r_datR;
  logic [XLEN-1:0] r_mem [DEPTH_WORDS];

  logic            w_req;
  logic            w_commit;
  logic [AW-1:0]   w_index;
  logic [1:0]      w_lane;
  logic            w_we;
  logic [3:0]      w_sel;
  logic [XLEN-1:0] w_datW;
  logic [XLEN-1:0] w_word;
  logic            w_unused;

  assign w_req = data_bus.CYC & data_bus.STB;

  // Address bits above the array size are dropped so addresses alias.
  assign w_unused = &{1'b0, data_bus.ADR[XLEN-1:AW+2]};

  // Next-state logic. A WAIT cycle with the request withdrawn aborts the
  // transfer, and that check wins over the counter expiring.
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_req) begin
          w_nextState = (WAIT_STATES > 0) ? S_WAIT : S_RESP;
        end
      end
      S_WAIT: begin
        if (!w_req) begin
          w_nextState = S_IDLE;
        end else if (r_count <= 4'd1) begin
          w_nextState = S_RESP;
        end
      end
      S_RESP:  w_nextState = S_IDLE;
      default: w_nextState = S_IDLE;
    endcase
  end

  // With zero wait states the access happens on the capture edge itself,
  // so the request is taken straight from the bus while in IDLE and from
  // the captured copy otherwise.
  always_comb begin
    w_index = r_index;
    w_lane  = r_lane;
    w_we    = r_we;
    w_sel   = r_sel;
    w_datW  = r_datW;
    if (r_state == S_IDLE) begin
      w_index = data_bus.ADR[AW+1:2];
      w_lane  = data_bus.ADR[1:0];
      w_we    = data_bus.WE;
      w_sel   = data_bus.SEL;
      w_datW  = data_bus.DAT_W;
    end
  end

  // The array is accessed exactly once per transfer, on the edge entering RESP.
  assign w_commit = (w_nextState == S_RESP) && (r_state != S_RESP);
  assign w_word   = r_mem[w_index];

  // State, wait counter, captured request and registered read data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_count <= 4'd0;
      r_index <= '0;
      r_lane  <= 2'd0;
      r_we    <= 1'b0;
      r_sel   <= 4'd0;
      r_datW  <= '0;
      r_datR  <= '0;
    end else begin
      r_state <= w_nextState;
      if (r_state == S_IDLE && w_req) begin
        r_count <= 4'(WAIT_STATES);
        r_index <= data_bus.ADR[AW+1:2];
        r_lane  <= data_bus.ADR[1:0];
        r_we    <= data_bus.WE;
        r_sel   <= data_bus.SEL;
        r_datW  <= data_bus.DAT_W;
      end else if (r_state == S_WAIT) begin
        r_count <= r_count - 4'd1;
      end
      if (w_commit && !w_we) begin
        r_datR <= w_word >> {w_lane, 3'b000};
      end
    end
  end

  // Byte-lane write into the array; no reset so contents survive rst.
  always_ff @(posedge clk) begin
    if (w_commit && w_we) begin
      for (int i = 0; i < 4; i++) begin
        if (w_sel[i]) begin
          r_mem[w_index][8*i +: 8] <= w_datW[8*i +: 8];
        end
      end
    end
  end

  assign data_bus.ACK   = (r_state == S_RESP);
  assign data_bus.DAT_R = r_datR;

endmodule

// File: tb/tb_wb_data_ram.sv
// tb_wb_data_ram
// Directed bench for wb_data_ram. Three instances with WAIT_STATES of 1, 3
// and 0 share clock, reset and one set of request drivers; 'tgt' steers the
// request to one instance and selects whose ACK/DAT_R are observed.
module tb_wb_data_ram;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  tgt = 2'd0;
  logic        cyc = 1'b0;
  logic        stb = 1'b0;
  logic        we = 1'b0;
  logic [31:0] adr = 32'd0;
  logic [31:0] datW = 32'd0;
  logic [3:0]  sel = 4'd0;
  logic        ack;
  logic [31:0] datR;

  int testsRun = 0;
  int testsFailed = 0;

  always #5 clk = ~clk;

  wb_data_ram_if #(.XLEN(32)) bus0 ();
  wb_data_ram_if #(.XLEN(32)) bus1 ();
  wb_data_ram_if #(.XLEN(32)) bus2 ();

  assign bus0.ADR = adr;  assign bus0.DAT_W = datW; assign bus0.SEL = sel;
  assign bus0.WE  = we;   assign bus0.STB = stb;    assign bus0.CYC = cyc && (tgt == 2'd0);
  assign bus1.ADR = adr;  assign bus1.DAT_W = datW; assign bus1.SEL = sel;
  assign bus1.WE  = we;   assign bus1.STB = stb;    assign bus1.CYC = cyc && (tgt == 2'd1);
  assign bus2.ADR = adr;  assign bus2.DAT_W = datW; assign bus2.SEL = sel;
  assign bus2.WE  = we;   assign bus2.STB = stb;    assign bus2.CYC = cyc && (tgt == 2'd2);

  assign ack  = (tgt == 2'd0) ? bus0.ACK   : (tgt == 2'd1) ? bus1.ACK   : bus2.ACK;
  assign datR = (tgt == 2'd0) ? bus0.DAT_R : (tgt == 2'd1) ? bus1.DAT_R : bus2.DAT_R;

  wb_data_ram #(.XLEN(32), .DEPTH_WORDS(1024), .WAIT_STATES(1)) dut0 (
    .clk(clk), .rst(rst), .data_bus(bus0.slave));
  wb_data_ram #(.XLEN(32), .DEPTH_WORDS(1024), .WAIT_STATES(3)) dut1 (
    .clk(clk), .rst(rst), .data_bus(bus1.slave));
  wb_data_ram #(.XLEN(32), .DEPTH_WORDS(1024), .WAIT_STATES(0)) dut2 (
    .clk(clk), .rst(rst), .data_bus(bus2.slave));

  // One LSU-style transfer: request just after an edge, wait up to 40 edges
  // for ACK, then drop the request. lat = -1 if ACK never came.
  task automatic xfer(input logic [1:0] target, input logic isWrite,
                      input logic [31:0] a, input logic [31:0] d,
                      input logic [3:0] s, output int lat,
                      output logic [31:0] rd);
    @(posedge clk); #1;
    tgt = target; cyc = 1'b1; stb = 1'b1; we = isWrite;
    adr = a; datW = d; sel = s;
    lat = -1;
    rd = 32'd0;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk); #1;
      if (ack) begin
        lat = i;
        rd = datR;
        break;
      end
    end
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
  endtask

  task automatic test_reset();
    #1;
    for (int k = 0; k < 3; k++) begin
      tgt = 2'(k); #1;
      testsRun++;
      if (ack !== 1'b0 || datR !== 32'd0) begin
        testsFailed++;
        $display("[TB] FAIL reset_outputs dut%0d: ack=%b datR=%h, required ack=0 datR=00000000", k, ack, datR);
      end
    end
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    tgt = 2'd0;
    testsRun++;
    if (ack !== 1'b0 || datR !== 32'd0) begin
      testsFailed++;
      $display("[TB] FAIL post_reset_outputs: ack=%b datR=%h, required ack=0 datR=00000000", ack, datR);
    end
  endtask

  task automatic test_word_rw();
    int lat;
    logic [31:0] rd;
    xfer(2'd0, 1'b1, 32'h10, 32'hDEADBEEF, 4'b1111, lat, rd);
    testsRun++;
    if (lat !== 2) begin
      testsFailed++;
      $display("[TB] FAIL word_write_latency: got %0d cycles, required 2", lat);
    end
    @(posedge clk); #1;
    testsRun++;
    if (ack !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL ack_width: ack=%b one cycle after ack, required 0", ack);
    end
    xfer(2'd0, 1'b0, 32'h10, 32'h0, 4'b0000, lat, rd);
    testsRun++;
    if (lat !== 2 || rd !== 32'hDEADBEEF) begin
      testsFailed++;
      $display("[TB] FAIL word_read: lat=%0d data=%h, required lat=2 data=deadbeef", lat, rd);
    end
  endtask

  task automatic test_byte_lanes();
    int lat;
    logic [31:0] rd;
    logic [31:0] addrs [3] = '{32'h12, 32'h13, 32'h11};
    logic [31:0] expv  [3] = '{32'h0000DEAA, 32'h000000DE, 32'h00DEAABE};
    xfer(2'd0, 1'b1, 32'h10, 32'h00AA0000, 4'b0100, lat, rd);
    for (int k = 0; k < 3; k++) begin
      xfer(2'd0, 1'b0, addrs[k], 32'h0, 4'b0000, lat, rd);
      testsRun++;
      if (lat !== 2 || rd !== expv[k]) begin
        testsFailed++;
        $display("[TB] FAIL lane_read@%h: lat=%0d data=%h, required lat=2 data=%h", addrs[k], lat, rd, expv[k]);
      end
    end
    xfer(2'd0, 1'b1, 32'h10, 32'hFFFFFFFF, 4'b0000, lat, rd);
    testsRun++;
    if (lat !== 2) begin
      testsFailed++;
      $display("[TB] FAIL sel0_write_ack: lat=%0d, required 2", lat);
    end
    testsRun++;
    if (datR !== 32'h00DEAABE) begin
      testsFailed++;
      $display("[TB] FAIL write_keeps_datr: datR=%h, required 00deaabe", datR);
    end
    xfer(2'd0, 1'b0, 32'h10, 32'h0, 4'b0000, lat, rd);
    testsRun++;
    if (rd !== 32'hDEAABEEF) begin
      testsFailed++;
      $display("[TB] FAIL sel0_no_change: data=%h, required deaabeef", rd);
    end
  endtask

  task automatic test_abort();
    int lat;
    logic [31:0] rd;
    logic sawAck;
    xfer(2'd1, 1'b1, 32'h20, 32'h0BADF00D, 4'b1111, lat, rd);
    testsRun++;
    if (lat !== 4) begin
      testsFailed++;
      $display("[TB] FAIL ws3_latency: got %0d cycles, required 4", lat);
    end
    @(posedge clk); #1;
    tgt = 2'd1; cyc = 1'b1; stb = 1'b1; we = 1'b1;
    adr = 32'h20; datW = 32'h12345678; sel = 4'b1111;
    @(posedge clk);
    @(posedge clk); #1;
    cyc = 1'b0;
    sawAck = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (ack) sawAck = 1'b1;
    end
    stb = 1'b0; we = 1'b0;
    testsRun++;
    if (sawAck !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL abort_no_ack: saw ack=%b, required 0", sawAck);
    end
    xfer(2'd1, 1'b0, 32'h20, 32'h0, 4'b0000, lat, rd);
    testsRun++;
    if (lat !== 4 || rd !== 32'h0BADF00D) begin
      testsFailed++;
      $display("[TB] FAIL abort_no_write: lat=%0d data=%h, required lat=4 data=0badf00d", lat, rd);
    end
  endtask

  task automatic test_alias();
    int lat;
    logic [31:0] rd;
    xfer(2'd0, 1'b1, 32'h1000, 32'hCAFEF00D, 4'b1111, lat, rd);
    xfer(2'd0, 1'b0, 32'h0000, 32'h0, 4'b0000, lat, rd);
    testsRun++;
    if (rd !== 32'hCAFEF00D) begin
      testsFailed++;
      $display("[TB] FAIL alias_read: data=%h, required cafef00d", rd);
    end
  endtask

  task automatic test_reset_midop();
    int lat;
    logic [31:0] rd;
    xfer(2'd0, 1'b1, 32'h30, 32'h600DCAFE, 4'b1111, lat, rd);
    xfer(2'd0, 1'b0, 32'h30, 32'h0, 4'b0000, lat, rd);
    testsRun++;
    if (rd !== 32'h600DCAFE) begin
      testsFailed++;
      $display("[TB] FAIL pre_reset_read: data=%h, required 600dcafe", rd);
    end
    @(posedge clk); #1;
    tgt = 2'd0; cyc = 1'b1; stb = 1'b1; we = 1'b1;
    adr = 32'h30; datW = 32'hFFFFFFFF; sel = 4'b1111;
    @(posedge clk); #3;
    rst = 1'b1;
    #1;
    testsRun++;
    if (ack !== 1'b0 || datR !== 32'd0) begin
      testsFailed++;
      $display("[TB] FAIL async_reset_outputs: ack=%b datR=%h, required ack=0 datR=00000000", ack, datR);
    end
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    #2;
    rst = 1'b0;
    xfer(2'd0, 1'b0, 32'h30, 32'h0, 4'b0000, lat, rd);
    testsRun++;
    if (lat !== 2 || rd !== 32'h600DCAFE) begin
      testsFailed++;
      $display("[TB] FAIL post_reset_read: lat=%0d data=%h, required lat=2 data=600dcafe", lat, rd);
    end
  endtask

  task automatic test_back_to_back();
    int lat;
    logic [31:0] rd;
    logic [31:0] addrs [3] = '{32'h40, 32'h44, 32'h48};
    logic [31:0] expv  [3] = '{32'h11112222, 32'h33334444, 32'h55556666};
    for (int k = 0; k < 3; k++) begin
      xfer(2'd2, 1'b1, addrs[k], expv[k], 4'b1111, lat, rd);
      testsRun++;
      if (lat !== 1) begin
        testsFailed++;
        $display("[TB] FAIL ws0_write_latency@%h: got %0d, required 1", addrs[k], lat);
      end
    end
    @(posedge clk); #1;
    tgt = 2'd2; cyc = 1'b1; stb = 1'b1; we = 1'b0; sel = 4'b1111;
    adr = addrs[0];
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      testsRun++;
      if (ack !== 1'b1 || datR !== expv[k]) begin
        testsFailed++;
        $display("[TB] FAIL b2b_read%0d: ack=%b data=%h, required ack=1 data=%h", k, ack, datR, expv[k]);
      end
      if (k < 2) adr = addrs[k+1];
      else begin
        cyc = 1'b0; stb = 1'b0;
      end
      @(posedge clk); #1;
      testsRun++;
      if (ack !== 1'b0) begin
        testsFailed++;
        $display("[TB] FAIL b2b_gap%0d: ack=%b, required 0", k, ack);
      end
    end
  endtask

  initial begin
    test_reset();
    test_word_rw();
    test_byte_lanes();
    test_abort();
    test_alias();
    test_reset_midop();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
